// File: rtl/pipe_stage_buf_pkg.sv
// ============================================================================
// pipe_stage_buf_pkg : shared state encoding, NOP constant and entry type
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned c_PC_W   = 32;
  localparam int unsigned c_DATA_W = 32;

  // Payload written into the main entry on reset and flush.
  localparam logic [31:0] c_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [c_PC_W-1:0]   pc;
    logic [c_DATA_W-1:0] data;
  } pipe_entry_t;

endpackage

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
// ============================================================================
// pipe_entry_reg : valid + {pc, data} holding register with load/drop/flush
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_entry_reg #(
  parameter int unsigned      PC_W      = 32,
  parameter int unsigned      DATA_W    = 32,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_data;

  // Flush keeps the PC so a debugger still sees where the bubble came from.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_data  <= FLUSH_VAL;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_data  <= FLUSH_VAL;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_pc    <= pc_i;
      r_data  <= data_i;
    end else if (drop_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign pc_o    = r_pc;
  assign data_o  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : valid/ready pipeline stage register with optional skid entry
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       SKID      = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(c_NOP),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_emit;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_main_drop;
  logic              w_skid_load;
  logic              w_skid_drop;

  logic              w_main_valid;
  logic              w_skid_valid;
  logic [PC_W-1:0]   w_skid_pc;
  logic [DATA_W-1:0] w_skid_data;
  logic [PC_W-1:0]   w_main_pc_d;
  logic [DATA_W-1:0] w_main_data_d;

  always_comb begin
    w_accept         = in_valid_i & w_in_ready & ~stall_i & ~flush_i;
    w_emit           = w_main_valid & out_ready_i & ~stall_i;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_drop      = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_drop      = 1'b0;
    w_state_nxt      = r_state;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_main_load = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_main_load = 1'b1;
        end else if (w_accept && (SKID != 0)) begin
          w_skid_load = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_emit) begin
          w_main_drop = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Skid entry is always older than anything still upstream.
        if (w_emit) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_drop      = 1'b1;
          w_state_nxt      = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_EMPTY;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i && (w_main_valid || w_skid_valid) && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign w_main_pc_d   = w_main_from_skid ? w_skid_pc   : pc_i;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : data_i;

  pipe_entry_reg #(
    .PC_W      (PC_W),
    .DATA_W    (DATA_W),
    .FLUSH_VAL (FLUSH_VAL)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .load_i  (w_main_load),
    .drop_i  (w_main_drop),
    .pc_i    (w_main_pc_d),
    .data_i  (w_main_data_d),
    .valid_o (w_main_valid),
    .pc_o    (pc_o),
    .data_o  (data_o)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      pipe_entry_reg #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
      ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (w_skid_load),
        .drop_i  (w_skid_drop),
        .pc_i    (pc_i),
        .data_i  (data_i),
        .valid_o (w_skid_valid),
        .pc_o    (w_skid_pc),
        .data_o  (w_skid_data)
      );

      // Ready looks at the next state so it never waits on stall_i combinationally.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_in_ready <= 1'b0;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_pc    = '0;
      assign w_skid_data  = '0;
      assign w_in_ready   = ~w_main_valid | out_ready_i;
    end
  endgenerate

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_main_valid;
  assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// tb_pipe_stage_buf : scoreboard bench for skid and single-entry builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Build A: SKID=1, defaults.
  logic        a_rst = 1'b1, a_flush = 1'b0, a_stall = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
  logic [31:0] a_pc_i = '0, a_data_i = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_pc_o, a_data_o;
  logic [15:0] a_cnt;

  // Build B: single entry, non-zero flush pattern, tiny counter.
  logic        b_rst = 1'b1, b_flush = 1'b0, b_stall = 1'b0, b_iv = 1'b0, b_ordy = 1'b0;
  logic [31:0] b_pc_i = '0, b_data_i = '0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_pc_o, b_data_o;
  logic [1:0]  b_cnt;

  pipe_entry_t qa[$];
  pipe_entry_t qb[$];
  pipe_entry_t ea, eb;

  pipe_stage_buf u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .stall_i(a_stall),
    .in_valid_i(a_iv), .in_ready_o(a_in_ready), .pc_i(a_pc_i), .data_i(a_data_i),
    .out_valid_o(a_out_valid), .out_ready_i(a_ordy), .pc_o(a_pc_o), .data_o(a_data_o),
    .flush_cnt_o(a_cnt)
  );

  pipe_stage_buf #(
    .PC_W(32), .DATA_W(32), .SKID(0), .FLUSH_VAL(32'h0000_0013), .CNT_W(2)
  ) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .stall_i(b_stall),
    .in_valid_i(b_iv), .in_ready_o(b_in_ready), .pc_i(b_pc_i), .data_i(b_data_i),
    .out_valid_o(b_out_valid), .out_ready_i(b_ordy), .pc_o(b_pc_o), .data_o(b_data_o),
    .flush_cnt_o(b_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; push marks a transfer the bench expects to be accepted.
  task automatic step_a(input logic rst, input logic flush, input logic stall, input logic iv,
                        input logic [31:0] pc, input logic [31:0] data, input logic ordy,
                        input bit push);
    a_rst = rst; a_flush = flush; a_stall = stall; a_iv = iv;
    a_pc_i = pc; a_data_i = data; a_ordy = ordy;
    if (push) qa.push_back('{pc: pc, data: data});
    @(negedge clk);
    @(posedge clk); #1;
    if (rst || flush) qa.delete();
  endtask

  task automatic step_b(input logic rst, input logic flush, input logic stall, input logic iv,
                        input logic [31:0] pc, input logic [31:0] data, input logic ordy,
                        input bit push);
    b_rst = rst; b_flush = flush; b_stall = stall; b_iv = iv;
    b_pc_i = pc; b_data_i = data; b_ordy = ordy;
    if (push) qb.push_back('{pc: pc, data: data});
    @(negedge clk);
    @(posedge clk); #1;
    if (rst || flush) qb.delete();
  endtask

  always @(negedge clk) begin
    if (!a_rst && !a_flush && !a_stall && a_out_valid && a_ordy) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_errors++;
        $display("FAIL a_emit unexpected pc %0h data %0h", a_pc_o, a_data_o);
      end else begin
        ea = qa.pop_front();
        if (a_pc_o !== ea.pc || a_data_o !== ea.data) begin
          n_errors++;
          $display("FAIL a_emit got pc %0h data %0h expected pc %0h data %0h",
                   a_pc_o, a_data_o, ea.pc, ea.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst && !b_flush && !b_stall && b_out_valid && b_ordy) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_errors++;
        $display("FAIL b_emit unexpected pc %0h data %0h", b_pc_o, b_data_o);
      end else begin
        eb = qb.pop_front();
        if (b_pc_o !== eb.pc || b_data_o !== eb.data) begin
          n_errors++;
          $display("FAIL b_emit got pc %0h data %0h expected pc %0h data %0h",
                   b_pc_o, b_data_o, eb.pc, eb.data);
        end
      end
    end
  end

  logic [31:0] s_pc   [3] = '{32'h100, 32'h104, 32'h108};
  logic [31:0] s_data [3] = '{32'h13, 32'h93, 32'h113};

  initial begin
    // ---------------- Build A (skid) ----------------
    step_a(1, 0, 0, 0, 0, 0, 0, 0);
    chk("a_rst_valid", a_out_valid, 0);
    chk("a_rst_pc", a_pc_o, 0);
    chk("a_rst_data", a_data_o, 0);
    chk("a_rst_cnt", a_cnt, 0);
    chk("a_rst_ready", a_in_ready, 0);
    step_a(0, 0, 0, 0, 0, 0, 1, 0);
    chk("a_ready_after_rst", a_in_ready, 1);

    for (int i = 0; i < 3; i++) begin
      step_a(0, 0, 0, 1, s_pc[i], s_data[i], 1, 1);
      chk("a_stream_valid", a_out_valid, 1);
      chk("a_stream_pc", a_pc_o, s_pc[i]);
      chk("a_stream_ready", a_in_ready, 1);
    end
    step_a(0, 0, 0, 0, 0, 0, 1, 0);
    chk("a_stream_drained", a_out_valid, 0);

    step_a(0, 0, 0, 1, 32'h200, 32'hA, 0, 1);
    chk("a_bp_one_ready", a_in_ready, 1);
    step_a(0, 0, 0, 1, 32'h204, 32'hB, 0, 1);
    chk("a_bp_two_ready", a_in_ready, 0);
    chk("a_bp_two_pc", a_pc_o, 32'h200);
    step_a(0, 0, 0, 1, 32'h2FF, 32'hC, 0, 0);
    chk("a_bp_full_ready", a_in_ready, 0);
    chk("a_bp_full_pc", a_pc_o, 32'h200);
    step_a(0, 0, 0, 0, 0, 0, 1, 0);
    chk("a_bp_first_emit_ready", a_in_ready, 1);
    chk("a_bp_skid_to_main_pc", a_pc_o, 32'h204);
    step_a(0, 0, 0, 0, 0, 0, 1, 0);
    chk("a_bp_drained", a_out_valid, 0);

    step_a(0, 0, 0, 1, 32'h300, 32'h33, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step_a(0, 0, 1, 1, 32'h310, 32'h31, 1, 0);
      chk("a_stall_valid", a_out_valid, 1);
      chk("a_stall_pc", a_pc_o, 32'h300);
      chk("a_stall_data", a_data_o, 32'h33);
    end
    step_a(0, 0, 0, 1, 32'h310, 32'h31, 1, 1);
    chk("a_stall_release_pc", a_pc_o, 32'h310);
    step_a(0, 0, 0, 0, 0, 0, 1, 0);

    step_a(0, 0, 0, 1, 32'h400, 32'h40, 0, 1);
    step_a(0, 0, 0, 1, 32'h404, 32'h44, 0, 1);
    step_a(0, 1, 0, 1, 32'h408, 32'h48, 0, 0);
    chk("a_flush_valid", a_out_valid, 0);
    chk("a_flush_data", a_data_o, 0);
    chk("a_flush_pc_hold", a_pc_o, 32'h400);
    chk("a_flush_ready", a_in_ready, 1);
    chk("a_flush_cnt", a_cnt, 1);
    step_a(0, 1, 1, 0, 0, 0, 0, 0);
    chk("a_flush_empty_cnt", a_cnt, 1);
    step_a(0, 0, 0, 1, 32'h410, 32'h41, 1, 1);
    step_a(0, 0, 0, 0, 0, 0, 1, 0);

    step_a(0, 0, 0, 1, 32'h500, 32'h50, 0, 1);
    step_a(0, 0, 0, 1, 32'h504, 32'h54, 0, 1);
    step_a(1, 1, 1, 1, 32'h508, 32'h58, 1, 0);
    chk("a_mrst_valid", a_out_valid, 0);
    chk("a_mrst_pc", a_pc_o, 0);
    chk("a_mrst_data", a_data_o, 0);
    chk("a_mrst_cnt", a_cnt, 0);
    chk("a_mrst_ready", a_in_ready, 0);
    step_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("a_mrst_ready_after", a_in_ready, 1);

    // ---------------- Build B (single entry) ----------------
    step_b(1, 0, 0, 0, 0, 0, 0, 0);
    chk("b_rst_data", b_data_o, 32'h13);
    chk("b_rst_valid", b_out_valid, 0);
    chk("b_rst_pc", b_pc_o, 0);
    chk("b_rst_cnt", b_cnt, 0);
    step_b(0, 0, 0, 1, 32'h600, 32'h60, 0, 1);
    chk("b_full_valid", b_out_valid, 1);
    chk("b_full_ready", b_in_ready, 0);
    step_b(0, 0, 0, 1, 32'h604, 32'h64, 0, 0);
    chk("b_hold_pc", b_pc_o, 32'h600);
    chk("b_hold_ready", b_in_ready, 0);
    step_b(0, 0, 0, 1, 32'h604, 32'h64, 1, 1);
    chk("b_replace_valid", b_out_valid, 1);
    chk("b_replace_pc", b_pc_o, 32'h604);
    chk("b_replace_ready", b_in_ready, 1);
    step_b(0, 0, 0, 1, 32'h608, 32'h68, 1, 1);
    chk("b_replace2_pc", b_pc_o, 32'h608);
    step_b(0, 0, 0, 0, 0, 0, 1, 0);
    chk("b_drained", b_out_valid, 0);

    for (int k = 1; k <= 4; k++) begin
      step_b(0, 0, 0, 1, 32'h700 + 32'(k * 4), 32'(k), 0, 1);
      step_b(0, 1, 0, 1, 32'h7F0, 32'h7F, 0, 0);
      chk("b_sat_cnt", b_cnt, (k > 3) ? 64'd3 : 64'(k));
    end
    chk("b_sat_flush_data", b_data_o, 32'h13);
    chk("b_sat_valid", b_out_valid, 0);

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register carrying a PC and an instruction word between two pipeline stages (IF/ID class and later boundaries).
- Generalises the plain stall/flush latch with a valid/ready handshake, an optional 2-entry skid buffer and a configurable flush pattern.
- Adds a saturating flush counter for performance monitoring.
- Sits between a producer stage and a consumer stage; timing is fully registered on the data path and on in_ready_o.

Parameters:
- PC_W, 32, width of the program-counter field.
- DATA_W, 32, width of the instruction/payload field.
- SKID, 1, 1 = 2-entry skid buffer (full throughput, registered ready); 0 = single entry.
- FLUSH_VAL, 0, payload value written into the main entry on flush and reset (NOP encoding).
- CNT_W, 16, width of the flush counter.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, synchronous active-high reset.
- flush_i, in, 1, discard all held entries this cycle.
- stall_i, in, 1, freeze stage: no accept, no emit.
- in_valid_i, in, 1, producer has a valid {pc, data}.
- in_ready_o, out, 1, stage can accept this cycle.
- pc_i, in, PC_W, incoming PC.
- data_i, in, DATA_W, incoming instruction.
- out_valid_o, out, 1, main entry valid.
- out_ready_i, in, 1, consumer accepts this cycle.
- pc_o, out, PC_W, PC of main entry.
- data_o, out, DATA_W, instruction of main entry.
- flush_cnt_o, out, CNT_W, number of flushes that discarded at least one valid entry, saturating.

Behaviour:
- Reset (rst_i=1 at edge): main/skid valid=0, pc_o=0, data_o=FLUSH_VAL, flush_cnt_o=0. Reset overrides flush and stall. The cycle after reset deasserts, in_ready_o=1.
- Handshakes: accept = in_valid_i & in_ready_o & !stall_i & !flush_i; emit = out_valid_o & out_ready_i & !stall_i.
- States (SKID=1):
  - EMPTY: accept -> ONE.
  - ONE: accept & !emit -> TWO (input to skid); accept & emit -> ONE (input to main); emit only -> EMPTY.
  - TWO: emit -> ONE (skid moves to main); input is never accepted.
- in_ready_o is registered: 1 in EMPTY/ONE, 0 in TWO, 0 during reset. It does not depend on stall_i combinationally; stall_i gates accept internally instead.
- SKID=0: states EMPTY/ONE only. in_ready_o = !out_valid_o | out_ready_i, a combinational bypass permitted. Accept & emit in ONE replaces the entry.
- Latency: accepted data appears on pc_o/data_o the next cycle. Throughput is 1 per cycle with out_ready_i held high.
- Ordering: strictly FIFO; the skid entry is always older than any new input.
- stall_i=1: all registers hold, including out_valid_o; no accept, no emit.
- flush_i=1 (stall_i is ignored):
  - Both valids clear; data_o := FLUSH_VAL; pc_o holds.
  - Input on that cycle is dropped.
  - Next state is EMPTY, with in_ready_o=1 next cycle.
- flush_cnt_o increments when flush_i & (main or skid valid). It saturates at all-ones.
- pc_o/data_o are stable whenever out_valid_o=1 and no emit occurs. Contents are don't-care when invalid, except after flush/reset (FLUSH_VAL).
- Data are never dropped except by flush.

Decomposition:
- Shared pipeline package holds: the state encoding (ST_EMPTY, ST_ONE, ST_TWO), the default NOP constant used for FLUSH_VAL, and the common {pc, data} entry struct.
- One sub-module is natural: pipe_entry_reg (valid + PC_W + DATA_W register with load/clear). It is instantiated for the main entry and, under SKID=1, for the skid entry.

Test Plan:
- Reset, then stream 0x100/0x13, 0x104/0x93, 0x108/0x113 with out_ready_i=1 -> each appears one cycle later, in order; in_ready_o stays 1; throughput 1 per cycle.
- Backpressure (SKID=1): out_ready_i=0, push A=0x200 and B=0x204 -> state TWO, in_ready_o=0 next cycle. Raise out_ready_i -> A then B emitted, in_ready_o returns to 1 after the first emit.
- Stall: state ONE holding 0x300, stall_i=1 for 3 cycles with in_valid_i=1 and out_ready_i=1 -> outputs unchanged, nothing accepted. Release -> 0x300 emitted, new input accepted.
- Flush with TWO occupied and in_valid_i=1 -> next cycle out_valid_o=0, data_o=FLUSH_VAL, in_ready_o=1, flush_cnt_o=1. Flush on EMPTY -> flush_cnt_o unchanged.
- Simultaneous rst_i, flush_i and stall_i mid-stream -> reset values on all outputs, flush_cnt_o=0.
- SKID=0 build: out_ready_i=0 with in_valid_i=1 -> in_ready_o=0 while full. Accept & emit in the same cycle replaces the entry with no bubble.
